// File: rtl/calc_op_scheduler_if.sv
// Request/operation/status bundle between the calculator scheduler (master)
// and the debouncers, arithmetic datapath and status display (slave side).
interface calc_op_scheduler_if;
  logic [3:0] Req;
  logic       Op_valid;
  logic [1:0] Op_code;
  logic       Op_ready;
  logic       Done;
  logic       Ovf;
  logic       Busy;
  logic       Locked;
  logic [2:0] Fifo_level;
  logic [7:0] Drop_cnt;

  modport master (
    input  Req, Op_ready, Done, Ovf,
    output Op_valid, Op_code, Busy, Locked, Fifo_level, Drop_cnt
  );

  modport slave (
    output Req, Op_ready, Done, Ovf,
    input  Op_valid, Op_code, Busy, Locked, Fifo_level, Drop_cnt
  );
endinterface

// File: rtl/calc_op_scheduler.sv
// Round-robin request arbiter feeding a 4-deep op FIFO and a one-at-a-time issue FSM.
// Optional CALC_OVF_LOCK_EN: overflow on Done locks the scheduler until Reset.
module calc_op_scheduler (
  input  logic                   Clk,
  input  logic                   Reset,
  calc_op_scheduler_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOCK} state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [1:0] op_code_q, op_code_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [1:0] fifo_mem [4];

  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic [3:0] grant_mask;
  logic [3:0] req_eff;
  logic [3:0] drops;
  logic [2:0] n_drops;
  logic [8:0] drop_sum;
  logic       pop;
  logic       flush;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rr_ptr_d   = rr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_code_d  = op_code_q;
    drop_cnt_d = drop_cnt_q;
    grant_vld  = 1'b0;
    grant_idx  = 2'd0;
    cand       = 2'd0;
    n_drops    = 3'd0;
    pop        = 1'b0;

    // Entering or sitting in LOCK wipes all queued and pending work.
`ifdef CALC_OVF_LOCK_EN
    flush = (state_q == LOCK) || (state_q == WAIT && bus.Done && bus.Ovf);
`else
    flush = 1'b0;
`endif

    req_eff = flush ? 4'd0 : bus.Req;

    if (!flush && count_q < 3'd4) begin
      for (int k = 0; k < 4; k++) begin
        cand = rr_ptr_q + 2'(k);
        if (!grant_vld && pend_q[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end

    grant_mask = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
    // A request on a bit granted this cycle re-arms it instead of dropping.
    drops      = req_eff & pend_q & ~grant_mask;
    pend_d     = flush ? 4'd0 : ((pend_q & ~grant_mask) | req_eff);

    for (int k = 0; k < 4; k++) begin
      n_drops = n_drops + {2'd0, drops[k]};
    end
    drop_sum   = {1'b0, drop_cnt_q} + {6'd0, n_drops};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    if (grant_vld) begin
      rr_ptr_d = grant_idx + 2'd1;
      wr_ptr_d = wr_ptr_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (count_q != 3'd0) begin
          op_code_d = fifo_mem[rd_ptr_q];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.Op_ready) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.Done) begin
`ifdef CALC_OVF_LOCK_EN
          state_d = bus.Ovf ? LOCK : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      LOCK: state_d = LOCK;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'd0, grant_vld} - {2'd0, pop};

    if (flush) begin
      count_d  = 3'd0;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      pend_q     <= 4'd0;
      rr_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      op_code_q  <= 2'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_code_q  <= op_code_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && grant_vld) begin
      fifo_mem[wr_ptr_q] <= grant_idx;
    end
  end

  assign bus.Op_valid   = (state_q == ISSUE);
  assign bus.Op_code    = op_code_q;
  assign bus.Fifo_level = count_q;
  assign bus.Drop_cnt   = drop_cnt_q;
  assign bus.Busy       = (state_q != IDLE) || (count_q != 3'd0) || (pend_q != 4'd0);
`ifdef CALC_OVF_LOCK_EN
  assign bus.Locked     = (state_q == LOCK);
`else
  assign bus.Locked     = 1'b0;
`endif

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Directed bench for calc_op_scheduler: latency, ordering, back-pressure,
// drop saturation, reset mid-issue and overflow handling (both builds).
module tb_calc_op_scheduler;
  logic Clk;
  logic Reset;
  int   tests_run;
  int   tests_failed;

  calc_op_scheduler_if bus();

  calc_op_scheduler dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.Op_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.Op_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset        = 1'b1;
    bus.Req      = 4'd0;
    bus.Op_ready = 1'b0;
    bus.Done     = 1'b0;
    bus.Ovf      = 1'b0;
    @(negedge Clk);
    tick();
    Reset = 1'b0;

    check("rst_op_valid", bus.Op_valid, 0);
    check("rst_op_code", bus.Op_code, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_locked", bus.Locked, 0);
    check("rst_level", bus.Fifo_level, 0);
    check("rst_drop", bus.Drop_cnt, 0);

    // Single request: Op_valid two edges after the Req edge.
    bus.Op_ready = 1'b1;
    bus.Req = 4'b0001;
    tick();
    bus.Req = 4'b0000;
    check("single_busy", bus.Busy, 1);
    check("single_valid_e1", bus.Op_valid, 0);
    tick();
    check("single_valid_e1b", bus.Op_valid, 0);
    tick();
    check("single_valid_e2", bus.Op_valid, 1);
    check("single_code", bus.Op_code, 0);
    check("single_level_e2", bus.Fifo_level, 1);
    tick();
    check("single_accept_valid", bus.Op_valid, 0);
    check("single_accept_level", bus.Fifo_level, 0);
    check("single_wait_busy", bus.Busy, 1);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    check("single_done_busy", bus.Busy, 0);

    // All four at once: issue order 0,1,2,3.
    do_reset();
    bus.Op_ready = 1'b1;
    bus.Req = 4'b1111;
    tick();
    bus.Req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("rr_%0d", i));
      check($sformatf("rr_code_%0d", i), bus.Op_code, i);
      tick();
      check($sformatf("rr_dropvalid_%0d", i), bus.Op_valid, 0);
      tick();
      bus.Done = 1'b1;
      tick();
      bus.Done = 1'b0;
    end
    check("rr_drop", bus.Drop_cnt, 0);
    check("rr_idle_busy", bus.Busy, 0);

    // Back-pressure: six pulses on Req[1] with the datapath stalled.
    do_reset();
    bus.Op_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      bus.Req = 4'b0010;
      tick();
      bus.Req = 4'b0000;
      tick();
      tick();
      if (p == 0) begin
        check("bp_first_valid", bus.Op_valid, 1);
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        check("bp_done_ignored", bus.Op_valid, 1);
      end
    end
    check("bp_level", bus.Fifo_level, 4);
    check("bp_pend1", dut.pend_q[1], 1);
    check("bp_drop", bus.Drop_cnt, 1);
    check("bp_code_stable", bus.Op_code, 1);

    // Saturation: 254 further drops reach 255, 45 more stay there.
    bus.Req = 4'b0010;
    for (int i = 0; i < 254; i++) tick();
    check("sat_255", bus.Drop_cnt, 255);
    for (int i = 0; i < 45; i++) tick();
    check("sat_hold", bus.Drop_cnt, 255);
    check("sat_level", bus.Fifo_level, 4);

    // Reset while in ISSUE, with a request in the same cycle.
    bus.Req = 4'b1111;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bus.Req = 4'b0000;
    check("rstmid_valid", bus.Op_valid, 0);
    check("rstmid_level", bus.Fifo_level, 0);
    check("rstmid_drop", bus.Drop_cnt, 0);
    check("rstmid_busy", bus.Busy, 0);
    tick();
    check("rstmid_req_ignored", bus.Busy, 0);

    // Overflow on Done with two operations still queued.
    do_reset();
    bus.Op_ready = 1'b0;
    bus.Req = 4'b0001;
    tick();
    bus.Req = 4'b0000;
    tick();
    tick();
    check("ovf_issue_code", bus.Op_code, 0);
    bus.Req = 4'b0110;
    tick();
    bus.Req = 4'b0000;
    tick();
    tick();
    check("ovf_level3", bus.Fifo_level, 3);
    bus.Op_ready = 1'b1;
    tick();
    bus.Op_ready = 1'b0;
    check("ovf_level2", bus.Fifo_level, 2);
    check("ovf_wait_valid", bus.Op_valid, 0);
    bus.Done = 1'b1;
    bus.Ovf  = 1'b1;
    tick();
    bus.Done = 1'b0;
    bus.Ovf  = 1'b0;
`ifdef CALC_OVF_LOCK_EN
    check("lock_locked", bus.Locked, 1);
    check("lock_level", bus.Fifo_level, 0);
    check("lock_valid", bus.Op_valid, 0);
    bus.Req = 4'b1111;
    bus.Op_ready = 1'b1;
    tick();
    bus.Req = 4'b0000;
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    tick();
    tick();
    bus.Op_ready = 1'b0;
    check("lock_valid_after_req", bus.Op_valid, 0);
    check("lock_level_after_req", bus.Fifo_level, 0);
    check("lock_still_locked", bus.Locked, 1);
    check("lock_busy", bus.Busy, 1);
    do_reset();
    check("lock_reset_locked", bus.Locked, 0);
    check("lock_reset_busy", bus.Busy, 0);
`else
    check("noovf_locked", bus.Locked, 0);
    check("noovf_level", bus.Fifo_level, 2);
    check("noovf_idle_valid", bus.Op_valid, 0);
    tick();
    check("noovf_next_valid", bus.Op_valid, 1);
    check("noovf_next_code", bus.Op_code, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/calc_op_scheduler.md
CALC_OP_SCHEDULER -- requirements
Module: calc_op_scheduler

Interface
REQ-001 SHALL have port Clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port Req, input, 4 bits: single-cycle operation request pulses from the debouncers (0:+1, 1:+2, 2:*2, 3:*3).
REQ-004 SHALL have port Op_valid, output, 1 bit: operation offered to the arithmetic datapath.
REQ-005 SHALL have port Op_code, output, 2 bits: operation index offered.
REQ-006 SHALL have port Op_ready, input, 1 bit: datapath accepts the offered operation.
REQ-007 SHALL have port Done, input, 1 bit: datapath finished the accepted operation (single-cycle pulse).
REQ-008 SHALL have port Ovf, input, 1 bit: overflow status, sampled only with Done.
REQ-009 SHALL have port Busy, output, 1 bit: high when state is not IDLE, or the FIFO is non-empty, or any pending bit is set.
REQ-010 SHALL have port Locked, output, 1 bit: scheduler is in state LOCK.
REQ-011 SHALL have port Fifo_level, output, 3 bits: queued operations, 0..4.
REQ-012 SHALL have port Drop_cnt, output, 8 bits: count of dropped requests, saturating.

Function
REQ-013 SHALL keep one pending bit per requester: Req[i]=1 at an edge sets pend[i].
REQ-014 SHALL drop a request when Req[i]=1 and pend[i] is already set and not granted in the same cycle, incrementing Drop_cnt, which saturates at 255.
REQ-015 SHALL, when Req[i]=1 in the same cycle pend[i] is granted, leave pend[i] set with no drop.
REQ-016 SHALL grant at most one pending bit per cycle, and only if Fifo_level<4, using round-robin starting from the index after the last grant.
REQ-017 SHALL push the granted index into a 4-deep FIFO and clear the granted pend bit.
REQ-018 SHALL, when Fifo_level=4, not grant; pending bits are held and not dropped.
REQ-019 SHALL allow a push and a pop in the same cycle, with Fifo_level unchanged.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, LOCK.
REQ-021 SHALL, in IDLE with Fifo_level>0, load Op_code from the FIFO head, set Op_valid=1, and go to ISSUE.
REQ-022 SHALL, in ISSUE, hold Op_valid and Op_code stable until Op_ready=1; on Op_ready it SHALL pop the FIFO, drop Op_valid, and go to WAIT.
REQ-023 SHALL, in WAIT, go to IDLE on Done (Ovf handling is in REQ-029); Op_valid SHALL be 0.
REQ-024 SHALL meet this latency: Req[i] at edge k, with the scheduler idle and empty, gives Op_valid=1 and Op_code=i after edge k+2.
REQ-025 SHALL ignore Done outside WAIT, and ignore Op_ready outside ISSUE.

Reset
REQ-026 SHALL, on Reset, set Op_valid=0, Op_code=0, Busy=0, Locked=0, Fifo_level=0, Drop_cnt=0, all pend bits clear, and state IDLE.
REQ-027 SHALL, on Reset, set the round-robin pointer so that index 0 has highest priority.
REQ-028 SHALL let Reset override everything, including mid-ISSUE or mid-WAIT and the LOCK state; a Req pulse in a Reset cycle SHALL be ignored.

Configuration
REQ-029 SHALL, with macro CALC_OVF_LOCK_EN defined, make Done with Ovf=1 in WAIT move to LOCK: the FIFO is flushed and pend is cleared; Req, Op_ready and Done are ignored; Op_valid=0; Locked=1; only Reset exits.
REQ-030 SHALL, without CALC_OVF_LOCK_EN, ignore Ovf: Done always returns to IDLE, LOCK is unreachable, and Locked is tied to 0.

Verification
REQ-031 SHALL cover a single request: Req=0001 at edge 0 with Op_ready=1 -> Op_valid=1 and Op_code=0 after edge 2, Fifo_level back to 0; Done -> Busy=0.
REQ-032 SHALL cover simultaneous requests: Req=1111 for one cycle with Done returned 2 cycles after each accept -> Op_code issue order 0,1,2,3 and Drop_cnt=0.
REQ-033 SHALL cover back-pressure: Op_ready=0, then 6 separate single pulses on Req[1] -> Fifo_level=4, pend[1]=1, Drop_cnt=1 (the 6th pulse).
REQ-034 SHALL cover saturation: 300 drop events -> Drop_cnt=255.
REQ-035 SHALL cover overflow with CALC_OVF_LOCK_EN: Done with Ovf=1 while 2 operations are queued -> Locked=1, Fifo_level=0, Op_valid stays 0 under further Req; Reset -> Locked=0.
REQ-036 SHALL cover reset mid-operation: Reset asserted in ISSUE -> next cycle Op_valid=0, state IDLE, Fifo_level=0, Drop_cnt=0.
